// File: rtl/mem_bus_arbiter.sv
// Two-port RAM arbiter: CPU vs debug/DMA master, round-robin with debug lock.
// Each grant runs IDLE -> ACCESS -> DONE, or IDLE -> DONE for out-of-map addresses.
module mem_bus_arbiter #(
    parameter int MEM_AW = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_done,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [15:0]       dbg_addr,
    input  logic [7:0]        dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_done,
    input  logic              dbg_lock,
    output logic [7:0]        rdata,
    output logic              err,
    output logic              cpu_stall,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_oe,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state, state_nxt;
    logic        own, last, we_q, err_q;
    logic        win, win_dbg, win_we, oom;
    logic [15:0] win_addr;
    logic [7:0]  win_wdata;
    logic        busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        win       = 1'b0;
        win_dbg   = 1'b0;
        win_we    = cpu_we;
        win_addr  = cpu_addr;
        win_wdata = cpu_wdata;
        oom       = 1'b0;
        case (state)
            IDLE: begin
                // Lock or a lone request or CPU-won-last all favour debug.
                if (dbg_req && (dbg_lock || !cpu_req || !last)) begin
                    win     = 1'b1;
                    win_dbg = 1'b1;
                end else if (cpu_req) begin
                    win = 1'b1;
                end
                if (win_dbg) begin
                    win_we    = dbg_we;
                    win_addr  = dbg_addr;
                    win_wdata = dbg_wdata;
                end
                oom = (win_addr >> MEM_AW) != 16'd0;
                if (win) state_nxt = oom ? DONE : ACCESS;
            end
            ACCESS:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            own       <= 1'b0;
            last      <= 1'b1;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
        end else begin
            if (win) begin
                own       <= win_dbg;
                last      <= win_dbg;
                we_q      <= win_we;
                err_q     <= oom;
                mem_addr  <= win_addr[MEM_AW-1:0];
                mem_wdata <= win_wdata;
            end
            if (state == ACCESS && !we_q) rdata <= mem_rdata;
        end
    end

    // Strobes decode straight from state so an async reset kills them at once.
    assign busy      = (state != IDLE);
    assign cpu_gnt   = busy && !own;
    assign dbg_gnt   = busy && own;
    assign cpu_done  = (state == DONE) && !own;
    assign dbg_done  = (state == DONE) && own;
    assign err       = (state == DONE) && err_q;
    assign mem_oe    = (state == ACCESS) && !we_q;
    assign mem_we    = (state == ACCESS) && we_q;
    assign cpu_stall = dbg_lock || (own && busy);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a small behavioural RAM on the memory port.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
    logic [15:0] cpu_addr, dbg_addr;
    logic [7:0]  cpu_wdata, dbg_wdata;
    logic        cpu_gnt, cpu_done, dbg_gnt, dbg_done, err, cpu_stall;
    logic [7:0]  rdata, mem_wdata, mem_rdata;
    logic [14:0] mem_addr;
    logic        mem_oe, mem_we;

    logic [7:0]  ram [0:32767];
    int          nvec = 0;
    int          nerr = 0;

    mem_bus_arbiter #(.MEM_AW(15)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_done(cpu_done),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_done(dbg_done), .dbg_lock(dbg_lock),
        .rdata(rdata), .err(err), .cpu_stall(cpu_stall),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_oe(mem_oe), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;
    assign mem_rdata = mem_oe ? ram[mem_addr] : 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        {cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock} = '0;
        cpu_addr = '0; dbg_addr = '0; cpu_wdata = '0; dbg_wdata = '0;
        #1;
        chk("rst_outs", {cpu_gnt, cpu_done, dbg_gnt, dbg_done, err, cpu_stall, mem_oe, mem_we}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_maddr", {mem_addr, mem_wdata}, 0);
        tick(); tick();
        reset = 1'b0;

        // CPU write 0xA5 -> 0x0010
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0010; cpu_wdata = 8'hA5;
        tick();
        chk("cw_strobe", {mem_we, mem_oe, cpu_gnt, dbg_gnt}, 4'b1010);
        chk("cw_addr", mem_addr, 15'h0010);
        chk("cw_wdata", mem_wdata, 8'hA5);
        cpu_req = 0;
        tick();
        chk("cw_done", {cpu_done, dbg_done, err, mem_we}, 4'b1000);
        chk("cw_rdata_hold", rdata, 8'h00);
        tick();
        chk("cw_idle", {cpu_gnt, cpu_done}, 0);

        // CPU read 0x0010
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        tick();
        chk("cr_strobe", {mem_oe, mem_we, cpu_gnt}, 3'b101);
        chk("cr_addr", mem_addr, 15'h0010);
        cpu_req = 0;
        tick();
        chk("cr_done", {cpu_done, dbg_done, mem_oe}, 3'b100);
        chk("cr_rdata", rdata, 8'hA5);
        tick();
        chk("cr_idle", {cpu_done, cpu_gnt, mem_oe}, 0);

        // Debug write 0x25 -> 0x0002, then read back
        dbg_req = 1; dbg_we = 1; dbg_addr = 16'h0002; dbg_wdata = 8'h25;
        tick();
        chk("dw_strobe", {mem_we, mem_oe, dbg_gnt, cpu_stall}, 4'b1011);
        chk("dw_wdata", mem_wdata, 8'h25);
        dbg_req = 0;
        tick();
        chk("dw_done", {dbg_done, cpu_done, cpu_stall, mem_we}, 4'b1010);
        tick();
        chk("dw_idle_stall", cpu_stall, 0);
        dbg_req = 1; dbg_we = 0;
        tick();
        dbg_req = 0;
        tick();
        chk("dr_done", dbg_done, 1);
        chk("dr_rdata", rdata, 8'h25);
        tick();

        // Tie after reset: CPU, dbg, CPU
        reset = 1; tick(); reset = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0002;
        tick();
        chk("tie1", {cpu_gnt, dbg_gnt}, 2'b10);
        tick();
        chk("tie1_rdata", rdata, 8'hA5);
        tick(); tick();
        chk("tie2", {cpu_gnt, dbg_gnt}, 2'b01);
        tick();
        chk("tie2_rdata", rdata, 8'h25);
        tick(); tick();
        chk("tie3", {cpu_gnt, dbg_gnt}, 2'b10);
        cpu_req = 0; dbg_req = 0;
        tick(); tick();

        // Locked debug burst with CPU held waiting
        dbg_lock = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        for (int i = 0; i < 16; i++) begin
            dbg_req = 1; dbg_we = 1; dbg_addr = 16'(i); dbg_wdata = 8'(255 - i);
            tick();
            chk("bw_gnt", {dbg_gnt, cpu_gnt, mem_we, cpu_stall}, 4'b1011);
            dbg_req = 0;
            tick();
            chk("bw_stall", cpu_stall, 1);
            tick();
            chk("bw_stall_idle", cpu_stall, 1);
        end
        for (int i = 0; i < 16; i++) begin
            dbg_req = 1; dbg_we = 0; dbg_addr = 16'(i);
            tick();
            chk("br_gnt", {dbg_gnt, cpu_gnt}, 2'b10);
            dbg_req = 0;
            tick();
            chk("br_rdata", rdata, 32'(255 - i));
            tick();
        end
        dbg_lock = 0;
        tick();
        chk("post_lock_cpu", {cpu_gnt, cpu_stall}, 2'b10);
        cpu_req = 0;
        tick();
        chk("post_lock_rd", {cpu_done, rdata}, {1'b1, 8'hA5});
        tick();

        // Out-of-map debug read
        dbg_req = 1; dbg_we = 0; dbg_addr = 16'h8000;
        tick();
        chk("oom_done", {dbg_done, err, dbg_gnt, cpu_done}, 4'b1110);
        chk("oom_strobe", {mem_oe, mem_we}, 0);
        chk("oom_rdata", rdata, 8'hA5);
        dbg_req = 0;
        tick();
        chk("oom_idle", {dbg_done, err, dbg_gnt, mem_oe, mem_we}, 0);

        // Reset during CPU write ACCESS
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0020; cpu_wdata = 8'h5A;
        tick();
        chk("rw_we", mem_we, 1);
        cpu_req = 0;
        #3 reset = 1;
        #1;
        chk("rw_async", {mem_we, mem_oe, cpu_gnt, cpu_done}, 0);
        tick();
        chk("rw_nodone", {cpu_done, dbg_done}, 0);
        reset = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0002;
        tick();
        chk("rw_tie", {cpu_gnt, dbg_gnt}, 2'b10);
        cpu_req = 0; dbg_req = 0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port arbiter and access sequencer for the single 8-bit-data / 16-bit-address RAM port. It shares the RAM between the CPU control unit and a debug/DMA master, which is used for bench loading, memory sweeps and future DMA. For each granted request it generates the RAM strobes (OE/WE), captures read data and flags out-of-map addresses. It sits between the requesters and the RAM, and replaces ad-hoc forcing of the address/data bus.

## Interface
- `MEM_AW`, default 15: RAM address width. Addresses with any bit at or above `MEM_AW` set are out of map.
- `clk`  in  1: clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-high.
- `cpu_req`  in  1: CPU access request. Held with its fields until `cpu_done`.
- `cpu_we`  in  1: 1 = write, 0 = read.
- `cpu_addr`  in  16: CPU address.
- `cpu_wdata`  in  8: CPU write data.
- `cpu_gnt`  out  1: CPU owns the RAM; high from ACCESS through DONE.
- `cpu_done`  out  1: one-cycle completion pulse for the CPU.
- `dbg_req`, `dbg_we`, `dbg_addr[15:0]`, `dbg_wdata[7:0]`, `dbg_gnt`, `dbg_done`: same meaning, debug master.
- `dbg_lock`  in  1: debug master keeps priority while high (burst mode).
- `rdata`  out  8: captured read data; valid while either `done` is high.
- `err`  out  1: high with `done` when the address was out of map.
- `cpu_stall`  out  1: freezes the control-unit timer.
- `mem_addr`  out  `MEM_AW`: RAM address.
- `mem_wdata`  out  8: RAM write data.
- `mem_oe`  out  1: RAM output enable.
- `mem_we`  out  1: RAM write enable.
- `mem_rdata`  in  8: RAM read data, combinational from `mem_addr` when `mem_oe` is high.

## Operation
- States:
  - IDLE: no owner; requests sampled.
  - ACCESS: RAM strobed.
  - DONE: completion pulse.
- Owner register `own` (0 = CPU, 1 = dbg); `last` records the most recent winner.
- IDLE, at each edge:
  - Neither request: stay in IDLE.
  - Exactly one request: that requester wins.
  - Both request: the requester that is not `last` wins (round-robin).
  - `dbg_lock` high and `dbg_req` high: dbg wins regardless of `last`.
- On a win, register the winner's `we`, `addr[MEM_AW-1:0]` and `wdata`, and set `own` and `last`. The upper address bits are checked at the same time:
  - Out of map: go straight to DONE with `err`=1. No RAM strobe is issued.
  - Otherwise go to ACCESS.
- ACCESS (one cycle):
  - `mem_oe` = !we, `mem_we` = we.
  - `mem_addr` and `mem_wdata` come from registers and are stable for the whole cycle.
  - At the exit edge, on a read, capture `mem_rdata` into `rdata`. On a write, `rdata` holds its previous value.
  - Always go to DONE.
- DONE (one cycle):
  - The owner's `done` is high; `err` is valid.
  - Then go to IDLE.
- `gnt` of the owner is high in ACCESS and DONE, and low in IDLE.
- `cpu_stall` = `dbg_lock` | (`own`==1 & state!=IDLE).
- `mem_addr` and `mem_wdata` hold their last values in IDLE. Strobes are low in every state except ACCESS.

## Timing
- Reset values: state IDLE, `last`=1 (so the CPU wins the first tie), `own`=0. All outputs are 0: `gnt`, `done`, `err`, `rdata`, `mem_*`, `cpu_stall`.
- Reset mid-access forces strobes low immediately (asynchronously). The interrupted transaction is dropped with no `done`.
- Request sampled at edge N:
  - Valid access: ACCESS during cycle N→N+1, `done` during N+1→N+2, IDLE from N+2.
  - Out-of-map access: `done`+`err` during N→N+1, IDLE from N+1.
- Next sample is at edge N+3 for a valid access, or N+2 for an error. Maximum throughput is one access per 3 cycles.
- A requester must drop `req` by the edge that ends its `done` cycle. If `req` is still high at the next IDLE sample, a new transaction starts.
- Changing `addr`, `we` or `wdata` while granted has no effect; the fields are registered at the win.
- Lock:
  - `dbg_lock` rising while the CPU owns the bus does not abort the CPU transaction. The CPU transaction completes, then dbg wins at the next tie.
  - `cpu_stall` follows `dbg_lock` in the same cycle, because it is combinational from the lock.

## Test plan
- CPU read: RAM[0x0010]=0xA5, `cpu_req` read 0x0010 sampled at edge N → `mem_oe` high for exactly cycle N→N+1, `mem_addr`=0x0010, `cpu_done` and `rdata`=0xA5 in cycle N+1, `dbg_done` stays 0.
- Debug write then read: dbg writes 0x25 to 0x0002 → `mem_we` high for one cycle, `mem_wdata`=0x25, `cpu_stall` high during ACCESS and DONE. A following dbg read of 0x0002 returns `rdata`=0x25.
- Tie: both request reads at the same edge after reset → CPU is granted first, dbg second. With both held continuously, grants alternate CPU, dbg, CPU.
- Lock burst: `dbg_lock`=1, dbg writes 255−i to addresses 0..15 while `cpu_req` is held → all 16 dbg transactions are served before the CPU, `cpu_stall` is constantly 1, and readback matches 255−i.
- Out of map: `dbg_req` read 0x8000 → `dbg_done`=`err`=1 one cycle after sampling, `mem_oe` and `mem_we` never assert, `rdata` unchanged.
- Reset during a CPU write's ACCESS cycle → `mem_we` drops before the next edge, no `done` pulse, and after release the next tie goes to the CPU.
